// File: rtl/gpu_pkg.sv
// gpu_pkg: shared defaults, frame writer state encoding and frame size helper.
package gpu_pkg;

    localparam int FMA_COUNT_DEF  = 2;
    localparam int ITERS_BITS_DEF = 4;

    typedef enum logic [1:0] {ACCEPT, DRAIN, WAIT_VSYNC} frame_writer_state_t;

    function automatic int pixels(input int width, input int height);
        return width * height;
    endfunction

endpackage

// File: rtl/frame_writer.sv
// frame_writer: paces FMA batches into frame buffer write bursts and swaps buffers on vsync.
module frame_writer
    import gpu_pkg::*;
#(
    parameter int FMA_COUNT  = FMA_COUNT_DEF,
    parameter int ITERS_BITS = ITERS_BITS_DEF,
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 160,
    localparam int BW        = FMA_COUNT * ITERS_BITS,
    localparam int PIXELS    = pixels(WIDTH, HEIGHT),
    localparam int AW        = $clog2(PIXELS)
) (
    input  logic          sys_clk_in,
    input  logic          rst_in,
    input  logic          batch_valid_in,
    input  logic [BW-1:0] batch_iters_in,
    output logic          batch_ready_out,
    input  logic          vsync_in,
    output logic          mandelbrot_iters_valid_out,
    output logic [BW-1:0] mandelbrot_iters_out,
    output logic [AW-1:0] addr_write_out,
    output logic          swap_out,
    output logic [15:0]   frame_count_out
);

    localparam int DRAIN_CYCLES = FMA_COUNT + 2;
    localparam int CW           = $clog2(DRAIN_CYCLES);

    frame_writer_state_t state, next_state;
    logic [CW-1:0] cnt;
    logic          vsync_q;
    logic          accept;
    logic          drain_end;
    logic          frame_end;
    logic          vsync_rise;

    always_comb begin
        accept     = 1'b0;
        drain_end  = 1'b0;
        frame_end  = 1'b0;
        vsync_rise = 1'b0;
        next_state = state;
        // ready is registered so it stays low on the cycle reset releases
        accept     = state == ACCEPT && batch_ready_out && batch_valid_in;
        drain_end  = state == DRAIN && cnt == CW'(DRAIN_CYCLES - 1);
        frame_end  = drain_end && (int'(addr_write_out) + FMA_COUNT == PIXELS);
        vsync_rise = state == WAIT_VSYNC && vsync_in && !vsync_q;
        next_state = accept ? DRAIN :
                     drain_end ? (frame_end ? WAIT_VSYNC : ACCEPT) :
                     vsync_rise ? ACCEPT : state;
    end

    always_ff @(posedge sys_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state                      <= ACCEPT;
            cnt                        <= '0;
            vsync_q                    <= 1'b0;
            batch_ready_out            <= 1'b0;
            mandelbrot_iters_valid_out <= 1'b0;
            mandelbrot_iters_out       <= '0;
            addr_write_out             <= '0;
            swap_out                   <= 1'b0;
            frame_count_out            <= '0;
        end else begin
            state                      <= next_state;
            vsync_q                    <= vsync_in;
            batch_ready_out            <= next_state == ACCEPT;
            mandelbrot_iters_valid_out <= accept;
            swap_out                   <= vsync_rise;
            cnt                        <= (state == DRAIN && !drain_end) ? cnt + CW'(1) : '0;
            if (accept)
                mandelbrot_iters_out <= batch_iters_in;
            if (drain_end && !frame_end)
                addr_write_out <= addr_write_out + AW'(FMA_COUNT);
            if (vsync_rise) begin
                addr_write_out  <= '0;
                frame_count_out <= frame_count_out + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_frame_writer.sv
// tb_frame_writer: scoreboard bench for a small 8x2 frame and a larger 320x50 frame.
module tb_frame_writer;

    typedef struct {
        int         a;
        logic [7:0] d;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        s_rst, s_valid, s_ready, s_vsync, s_ov, s_swap;
    logic [7:0]  s_data, s_od;
    logic [3:0]  s_oa;
    logic [15:0] s_fc;

    logic        b_rst, b_valid, b_ready, b_vsync, b_ov, b_swap;
    logic [7:0]  b_data, b_od;
    logic [13:0] b_oa;
    logic [15:0] b_fc;

    frame_writer #(.FMA_COUNT(2), .ITERS_BITS(4), .WIDTH(8), .HEIGHT(2)) dut_s (
        .sys_clk_in(clk), .rst_in(s_rst),
        .batch_valid_in(s_valid), .batch_iters_in(s_data), .batch_ready_out(s_ready),
        .vsync_in(s_vsync),
        .mandelbrot_iters_valid_out(s_ov), .mandelbrot_iters_out(s_od),
        .addr_write_out(s_oa), .swap_out(s_swap), .frame_count_out(s_fc)
    );

    frame_writer #(.FMA_COUNT(2), .ITERS_BITS(4), .WIDTH(320), .HEIGHT(50)) dut_b (
        .sys_clk_in(clk), .rst_in(b_rst),
        .batch_valid_in(b_valid), .batch_iters_in(b_data), .batch_ready_out(b_ready),
        .vsync_in(b_vsync),
        .mandelbrot_iters_valid_out(b_ov), .mandelbrot_iters_out(b_od),
        .addr_write_out(b_oa), .swap_out(b_swap), .frame_count_out(b_fc)
    );

    exp_t sq[$];
    exp_t bq[$];
    int   s_exp = 0;
    int   b_exp = 0;
    int   s_swaps = 0;
    int   b_swaps = 0;
    int   b_bursts = 0;
    int   b_last_addr = -1;
    int   s_last_cyc = -1;
    logic spacing_on = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (s_swap) s_swaps++;
        if (s_ov) begin
            checks++;
            if (sq.size() == 0) begin
                errors++;
                $display("FAIL s_burst unexpected addr=%0d data=%h", s_oa, s_od);
            end else begin
                e = sq.pop_front();
                if (int'(s_oa) != e.a || s_od != e.d) begin
                    errors++;
                    $display("FAIL s_burst got addr=%0d data=%h want addr=%0d data=%h", s_oa, s_od, e.a, e.d);
                end
            end
            if (spacing_on && s_last_cyc >= 0) begin
                checks++;
                if (cyc - s_last_cyc != 5) begin
                    errors++;
                    $display("FAIL s_spacing got %0d want 5", cyc - s_last_cyc);
                end
            end
            s_last_cyc = cyc;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b_swap) b_swaps++;
        if (b_ov) begin
            checks++;
            b_bursts++;
            b_last_addr = int'(b_oa);
            if (bq.size() == 0) begin
                errors++;
                $display("FAIL b_burst unexpected addr=%0d data=%h", b_oa, b_od);
            end else begin
                e = bq.pop_front();
                if (int'(b_oa) != e.a || b_od != e.d) begin
                    errors++;
                    $display("FAIL b_burst got addr=%0d data=%h want addr=%0d data=%h", b_oa, b_od, e.a, e.d);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic s_send(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("s_send_ready", int'(s_ready), 1);
        if (s_ready) begin
            sq.push_back('{s_exp, d});
            s_exp = (s_exp + 2) % 16;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic b_send(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        b_valid = 1'b1;
        b_data  = d;
        while (!b_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b_send_ready", int'(b_ready), 1);
        if (b_ready) begin
            bq.push_back('{b_exp, d});
            b_exp = (b_exp + 2) % 16000;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic s_reset();
        @(negedge clk);
        s_rst = 1'b1;
        s_exp = 0;
        @(negedge clk);
        s_rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        s_rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_vsync = 1'b0;
        b_rst = 1'b1; b_valid = 1'b0; b_data = 8'h00; b_vsync = 1'b0;
        idle(2);
        chk("rst_ready", int'(s_ready), 0);
        chk("rst_valid", int'(s_ov), 0);
        chk("rst_addr", int'(s_oa), 0);
        chk("rst_swap", int'(s_swap), 0);
        chk("rst_fc", int'(s_fc), 0);
        s_rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", int'(s_ready), 1);

        // single batch, ready low for exactly four cycles, outputs held
        s_send(8'hA5);
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_ready_low", int'(s_ready), 0);
            chk("t1_hold_addr", int'(s_oa), 0);
            chk("t1_hold_data", int'(s_od), 8'hA5);
        end
        @(negedge clk);
        chk("t1_ready_back", int'(s_ready), 1);

        // back-to-back batches fill one frame
        s_reset();
        spacing_on = 1'b1;
        s_last_cyc = -1;
        for (int i = 0; i < 8; i++) s_send(8'(i * 17 + 3));
        s_valid = 1'b0;
        idle(6);
        spacing_on = 1'b0;
        chk("t2_drained", sq.size(), 0);

        // swap waits for the vsync rising edge
        s0 = s_swaps;
        idle(20);
        chk("t3_no_swap", s_swaps - s0, 0);
        chk("t3_ready_wait", int'(s_ready), 0);
        @(negedge clk);
        s_vsync = 1'b1;
        idle(3);
        chk("t3_swap", s_swaps - s0, 1);
        chk("t3_fc", int'(s_fc), 1);
        s_send(8'h5A);
        s_valid = 1'b0;

        // vsync already high at frame end; batch held on valid is not taken while waiting
        for (int i = 1; i < 8; i++) s_send(8'(8'hF0 - i));
        s_data = 8'h3C;
        s0 = s_swaps;
        idle(12);
        chk("t4_no_swap_high", s_swaps - s0, 0);
        @(negedge clk);
        s_vsync = 1'b0;
        idle(3);
        chk("t4_no_swap_fall", s_swaps - s0, 0);
        @(negedge clk);
        s_vsync = 1'b1;
        s_send(8'h3C);
        s_valid = 1'b0;
        idle(2);
        chk("t4_swap", s_swaps - s0, 1);
        chk("t4_fc", int'(s_fc), 2);
        idle(4);

        // asynchronous reset in the middle of a drain
        s_send(8'hC3);
        s_valid = 1'b0;
        @(posedge clk);
        #2;
        s_rst = 1'b1;
        #1;
        chk("t5_valid", int'(s_ov), 0);
        chk("t5_data", int'(s_od), 0);
        chk("t5_addr", int'(s_oa), 0);
        chk("t5_ready", int'(s_ready), 0);
        chk("t5_fc", int'(s_fc), 0);
        @(negedge clk);
        s_rst = 1'b0;
        s_exp = 0;
        s_send(8'h99);
        s_valid = 1'b0;
        idle(6);
        chk("t5_drained", sq.size(), 0);

        // larger frame with random gaps between batches
        b_rst = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            int gap = $urandom_range(0, 1);
            if (gap != 0) begin
                b_valid = 1'b0;
                idle(gap);
            end
            b_send(8'($urandom));
        end
        b_valid = 1'b0;
        idle(10);
        chk("t6_no_swap_early", b_swaps, 0);
        @(negedge clk);
        b_vsync = 1'b1;
        idle(3);
        chk("t6_swaps", b_swaps, 1);
        chk("t6_fc", int'(b_fc), 1);
        chk("t6_last_addr", b_last_addr, 15998);
        chk("t6_bursts", b_bursts, 8000);
        chk("t6_drained", bq.size(), 0);
        chk("t6_addr_reset", int'(b_oa), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
